// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: op_data bit positions, ALU command encodings and
// the EX-stage controller states.
package pipe_pkg;

   localparam int unsigned LOAD_BIT         = 0;
   localparam logic [4:0]  ALU_NOP          = 5'd0;
   localparam int unsigned MC_CMD_BASE_DFLT = 16;

   typedef enum logic {
      RUN   = 1'b0,
      MULTI = 1'b1
   } state_t;

   // Control fields carried from ID/EX into EX/MEM
   typedef struct packed {
      logic [4:0]  rd;
      logic [14:0] op_data;
      logic [2:0]  func3;
   } exmem_ctl_t;

endpackage

// File: rtl/stage2_hazard.sv
// EX-side compare logic: RAW hazard against EX/MEM, multi-cycle start detection
// and, with STAGE2_FWD_EN defined, EX/MEM -> EX forwarding selects.
module stage2_hazard
   import pipe_pkg::*;
#(
   parameter int unsigned MC_CMD_BASE = MC_CMD_BASE_DFLT
) (
   input  logic       state_run,
   input  logic       in_valid,
   input  logic [4:0] alu_cmd,
   input  logic [4:0] r1,
   input  logic [4:0] r2,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
`ifdef STAGE2_FWD_EN
   input  logic       ex_load,
   output logic       fwd_a,
   output logic       fwd_b,
`endif
   output logic       hazard,
   output logic       mc_start
);

   logic ex_writes;
   logic raw;

   // x0 is never a real producer
   assign ex_writes = ex_valid && (ex_rd != 5'd0);
   assign raw       = (ex_rd == r1) || (ex_rd == r2);

`ifdef STAGE2_FWD_EN
   // Only a load result arrives too late to forward
   assign hazard = ex_writes && ex_load && in_valid && raw;
   assign fwd_a  = ex_writes && !ex_load && (ex_rd == r1);
   assign fwd_b  = ex_writes && !ex_load && (ex_rd == r2);
`else
   assign hazard = ex_writes && in_valid && raw;
`endif

   assign mc_start = state_run && in_valid && (32'(alu_cmd) >= MC_CMD_BASE) && !hazard;

endmodule

// File: rtl/stage2.sv
// EX/MEM pipeline register with EX-side hazard control (bubbles, multi-cycle stall,
// branch flush). Define STAGE2_FWD_EN to add forwarding outputs fwd_a/fwd_b.
module stage2
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MC_LAT      = 4,
   parameter int unsigned MC_CMD_BASE = MC_CMD_BASE_DFLT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      r1_in,
   input  logic [4:0]      r2_in,
   input  logic [4:0]      rd_in,
   input  logic [XLEN-1:0] PC_in,
   input  logic [14:0]     op_data_in,
   input  logic [2:0]      func3_in,
   input  logic [4:0]      ALU_command_in,
   input  logic [XLEN-1:0] alu_result,
   input  logic            flush,
   output logic            stage1_en,
   output logic [4:0]      rd_out,
   output logic [XLEN-1:0] result_out,
   output logic [XLEN-1:0] PC_out,
   output logic [14:0]     op_data_out,
   output logic [2:0]      func3_out,
   output logic            valid_out,
`ifdef STAGE2_FWD_EN
   output logic            fwd_a,
   output logic            fwd_b,
`endif
   output logic            busy_out
);

   localparam int unsigned CNT_W = $clog2(MC_LAT);

   state_t          state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   exmem_ctl_t      ctl_q;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;

   logic in_valid;
   logic hazard;
   logic mc_start;
   logic capture;
   logic capture_valid;

   // stage1's reset contents double as the bubble encoding
   assign in_valid = !((ALU_command_in == ALU_NOP) && (op_data_in == 15'd0));

   stage2_hazard #(
      .MC_CMD_BASE (MC_CMD_BASE)
   ) u_hazard (
      .state_run (state == RUN),
      .in_valid  (in_valid),
      .alu_cmd   (ALU_command_in),
      .r1        (r1_in),
      .r2        (r2_in),
      .ex_valid  (valid_q),
      .ex_rd     (ctl_q.rd),
`ifdef STAGE2_FWD_EN
      .ex_load   (ctl_q.op_data[LOAD_BIT]),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
`endif
      .hazard    (hazard),
      .mc_start  (mc_start)
   );

   // Next state; priority flush > MULTI > hazard > mc_start > normal
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      capture       = 1'b0;
      capture_valid = 1'b0;
      if (flush) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (state == MULTI) begin
         if (cnt != '0) begin
            cnt_d = cnt - CNT_W'(1);
         end else begin
            capture       = 1'b1;
            capture_valid = 1'b1;
            state_d       = RUN;
         end
      end else if (hazard) begin
         state_d = RUN;
      end else if (mc_start) begin
         state_d = MULTI;
         cnt_d   = CNT_W'(MC_LAT - 1);
      end else begin
         capture       = 1'b1;
         capture_valid = in_valid;
      end
   end

   assign stage1_en = rst && (flush
                           || ((state == RUN) && !hazard && !mc_start)
                           || ((state == MULTI) && (cnt == '0)));

   // Anything not captured is a bubble: only valid and rd are cleared
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= RUN;
         cnt      <= '0;
         valid_q  <= 1'b0;
         ctl_q    <= '0;
         result_q <= '0;
         pc_q     <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (capture) begin
            valid_q       <= capture_valid;
            ctl_q.rd      <= rd_in;
            ctl_q.op_data <= op_data_in;
            ctl_q.func3   <= func3_in;
            result_q      <= alu_result;
            pc_q          <= PC_in;
         end else begin
            valid_q  <= 1'b0;
            ctl_q.rd <= 5'd0;
         end
      end
   end

   assign rd_out      = ctl_q.rd;
   assign op_data_out = ctl_q.op_data;
   assign func3_out   = ctl_q.func3;
   assign result_out  = result_q;
   assign PC_out      = pc_q;
   assign valid_out   = valid_q;
   assign busy_out    = (state == MULTI);

endmodule

// File: doc/stage2.md
Name: stage2

Overview:
- EX/MEM pipeline register and EX-side hazard controller. It is the consumer end of the ID/EX latch (stage1).
- Registers the ID/EX fields plus the ALU result into EX/MEM.
- Drives the ID/EX latch enable: stalls it for load-use hazards and for multi-cycle ALU commands, and inserts bubbles into EX/MEM.
- Handles branch flush.

Parameters:
- XLEN, 32, datapath width.
- MC_LAT, 4, execute cycles of a multi-cycle ALU command (>=2).
- MC_CMD_BASE, 16, ALU_command values >= this are multi-cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- r1_in  in  5  ID/EX source reg 1.
- r2_in  in  5  ID/EX source reg 2.
- rd_in  in  5  ID/EX destination reg.
- PC_in  in  XLEN  ID/EX PC.
- op_data_in  in  15  ID/EX op data. Bit LOAD_BIT marks a load.
- func3_in  in  3  ID/EX func3.
- ALU_command_in  in  5  ID/EX ALU command.
- alu_result  in  XLEN  combinational ALU output for the current ID/EX contents.
- flush  in  1  taken branch; kill the EX instruction.
- stage1_en  out  1  enable to the ID/EX latch and fetch. Combinational.
- rd_out  out  5  EX/MEM destination reg.
- result_out  out  XLEN  EX/MEM ALU result.
- PC_out  out  XLEN  EX/MEM PC.
- op_data_out  out  15  EX/MEM op data.
- func3_out  out  3  EX/MEM func3.
- valid_out  out  1  EX/MEM holds a real instruction.
- busy_out  out  1  multi-cycle op in progress (state==MULTI).

Behaviour:
- Reset (rst low at posedge): all registered outputs 0, state RUN, counter 0. stage1_en is forced 0 while rst is low. Reset mid-MULTI aborts the operation, with no result written.
- Bubble encoding: the ID/EX entry is a bubble when ALU_command_in==0 and op_data_in==0. This matches stage1's reset contents.
- in_valid = not bubble.
- Bubble into EX/MEM means valid_out<=0 and rd_out<=0. All other EX/MEM fields are don't-care but are held.
- hazard: valid_out, op_data_out[LOAD_BIT], rd_out!=0, in_valid, and (rd_out==r1_in or rd_out==r2_in).
- mc_start: state RUN, in_valid, ALU_command_in>=MC_CMD_BASE, no hazard.
- stage1_en = rst and (flush or (state==RUN and not hazard and not mc_start) or (state==MULTI and cnt==0)).
- Priority per edge: reset > flush > MULTI > hazard > mc_start > normal.
- Flush: insert a bubble into EX/MEM; state RUN; cnt 0. stage1_en=1 that cycle so the wrong-path entry is replaced.
- RUN, normal: capture all ID/EX fields and alu_result. valid_out<=in_valid. Latency is 1 edge.
- RUN, hazard: insert a bubble; ID/EX is held. The hazard lasts exactly one cycle, because the bubble clears it.
- RUN, mc_start: insert a bubble; state MULTI; cnt<=MC_LAT-1.
- MULTI, cnt!=0: cnt decrements; insert a bubble; stage1_en=0.
- MULTI, cnt==0: capture the fields and alu_result; valid_out<=1; state RUN.
- Multi-cycle timing: stage1_en is low for exactly MC_LAT consecutive cycles. The ID/EX entry is held for MC_LAT+1 cycles.
- x0: rd==0 never creates a hazard. Comparisons use the 5-bit fields only.
- Counter width is $clog2(MC_LAT). It never wraps: it only decrements in MULTI with cnt!=0.

Optional Feature:
- Macro STAGE2_FWD_EN.
- Defined:
  - Adds outputs fwd_a and fwd_b (1 bit each). fwd_a = valid_out, not load, rd_out!=0, rd_out==r1_in. fwd_b is the same with r2_in.
  - Load-use stall behaviour is unchanged.
- Undefined:
  - No forwarding ports.
  - hazard drops the LOAD_BIT term, so any RAW dependency against EX/MEM causes a one-cycle bubble.

Decomposition:
- Shared package pipe_pkg holds:
  - LOAD_BIT (op_data bit index, 0).
  - ALU_NOP = 5'd0.
  - MC_CMD_BASE default.
  - State enum {RUN, MULTI}.
- One natural sub-module, stage2_hazard: combinational hazard, mc_start and forwarding compare logic.
- FSM and registers stay in stage2.

Test Plan:
- Reset: rst low for 2 cycles with non-zero inputs -> all outputs 0, stage1_en=0. After release with bubble inputs -> stage1_en=1, valid_out=0.
- Single-cycle op: ALU_command_in=3, rd_in=5, alu_result=0x1234 -> next edge rd_out=5, result_out=0x1234, valid_out=1, stage1_en stays 1.
- Multi-cycle op: ALU_command_in=16, MC_LAT=4 -> stage1_en low 4 cycles, busy_out high 4 cycles, valid_out=0 throughout, then result captured with valid_out=1 on the 5th edge.
- Load-use: EX/MEM holds a load with rd_out=7, ID/EX r2_in=7 -> stage1_en=0 for one cycle and a bubble is inserted. Next cycle stage1_en=1 and the dependent instruction is captured. Repeating with rd=0 -> no stall.
- Flush during MULTI (cnt=2): flush=1 -> next edge state RUN, valid_out=0, busy_out=0, stage1_en=1 in the flush cycle.
- STAGE2_FWD_EN: EX/MEM holds a non-load with rd_out=9, r1_in=9 -> fwd_a=1, no stall. Without the macro -> one bubble.
